// File: rtl/simd_cmd_queue.sv
// Purpose : command FIFO from the scalar core's vector-control write port to the vector core.
// Latency : push in cycle N is presented (VEC_CMD_VALID) in cycle N+1; same cycle with bypass.
// Backpr. : CORE_BUSY is high while full; a push while full with no pop is dropped and sets OVERFLOW.
//
// Ports:
//   CLK, RESET_N        clock, asynchronous active-low reset
//   CONTROL_DATA/_WR    command word and push request from the scalar core
//   CORE_BUSY           queue full, scalar core must hold CONTROL_WR low
//   FLUSH               synchronous clear of all queued commands (OVERFLOW kept)
//   VEC_CMD_DATA/VALID  head-of-queue command to the vector core
//   VEC_CMD_READY       vector core accepts the head command this cycle
//   VEC_BUSY            vector core is executing a command
//   CMD_COUNT           registered occupancy (0..DEPTH)
//   OVERFLOW            sticky dropped-push flag, cleared only by reset
//   SIMD_IDLE           queue empty and vector core not busy
//
// Build option: define SIMD_CMDQ_BYPASS_EN to present a push into an empty queue
// combinationally in the same cycle (consumed without being stored if accepted).
module simd_cmd_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DATA_WIDTH-1:0] CONTROL_DATA,
  input  logic                  CONTROL_WR,
  output logic                  CORE_BUSY,
  input  logic                  FLUSH,
  output logic [DATA_WIDTH-1:0] VEC_CMD_DATA,
  output logic                  VEC_CMD_VALID,
  input  logic                  VEC_CMD_READY,
  input  logic                  VEC_BUSY,
  output logic [CNT_WIDTH-1:0]  CMD_COUNT,
  output logic                  OVERFLOW,
  output logic                  SIMD_IDLE
);

  localparam int                   PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Storage is deliberately not reset; only the pointers and count define validity.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic empty;
  logic full;
  logic bypass_vld;   // an incoming push is being shown on the output this cycle
  logic pop;          // handshake completes this cycle
  logic mem_pop;      // handshake consumes a stored entry
  logic push;         // incoming command is accepted (stored or bypassed)
  logic store;        // accepted command is written into the buffer

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

`ifdef SIMD_CMDQ_BYPASS_EN
  assign bypass_vld   = CONTROL_WR & empty & ~FLUSH;
  assign VEC_CMD_DATA = empty ? CONTROL_DATA : mem_q[rptr_q];
`else
  assign bypass_vld   = 1'b0;
  assign VEC_CMD_DATA = mem_q[rptr_q];
`endif

  assign VEC_CMD_VALID = ~empty | bypass_vld;
  assign CORE_BUSY     = full;
  assign SIMD_IDLE     = empty & ~VEC_BUSY;
  assign CMD_COUNT     = count_q;
  assign OVERFLOW      = ovf_q;

  // FLUSH wins over both sides of the handshake.
  assign pop     = VEC_CMD_VALID & VEC_CMD_READY & ~FLUSH;
  assign mem_pop = pop & ~empty;

  // A full queue can still take a push when the head leaves in the same cycle.
  assign push  = CONTROL_WR & ~FLUSH & (~full | pop);

  // A bypassed command that is accepted immediately never touches the buffer.
  assign store = push & ~(bypass_vld & VEC_CMD_READY);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (CONTROL_WR && !FLUSH && full && !pop) begin
      ovf_d = 1'b1;
    end

    if (FLUSH) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (store) begin
        wptr_d = wptr_q + PTR_ONE;   // power-of-two depth: wraps naturally
      end
      if (mem_pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      case ({store, mem_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (store) begin
      mem_q[wptr_q] <= CONTROL_DATA;
    end
  end

endmodule

// File: tb/tb_simd_cmd_queue.sv
`timescale 1ns/1ps
module tb_simd_cmd_queue;

  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK;
  logic          RESET_N;
  logic [DW-1:0] CONTROL_DATA;
  logic          CONTROL_WR;
  logic          CORE_BUSY;
  logic          FLUSH;
  logic [DW-1:0] VEC_CMD_DATA;
  logic          VEC_CMD_VALID;
  logic          VEC_CMD_READY;
  logic          VEC_BUSY;
  logic [CW-1:0] CMD_COUNT;
  logic          OVERFLOW;
  logic          SIMD_IDLE;

  simd_cmd_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .CONTROL_DATA (CONTROL_DATA),
    .CONTROL_WR   (CONTROL_WR),
    .CORE_BUSY    (CORE_BUSY),
    .FLUSH        (FLUSH),
    .VEC_CMD_DATA (VEC_CMD_DATA),
    .VEC_CMD_VALID(VEC_CMD_VALID),
    .VEC_CMD_READY(VEC_CMD_READY),
    .VEC_BUSY     (VEC_BUSY),
    .CMD_COUNT    (CMD_COUNT),
    .OVERFLOW     (OVERFLOW),
    .SIMD_IDLE    (SIMD_IDLE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected queue contents, in order; the monitor pops from the front.
  logic [DW-1:0] exp_q[$];
  bit            ovf_m;
  int            n_chk  = 0;
  int            n_pass = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: every completed handshake must deliver the next expected command.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && VEC_CMD_VALID === 1'b1 && VEC_CMD_READY === 1'b1 && FLUSH === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pop: got %0h, expected no handshake (t=%0t)", VEC_CMD_DATA, $time);
      end else begin
        chk("pop_data", VEC_CMD_DATA, exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus: check registered/combinational outputs against the
  // model, then record what this cycle should enqueue.
  task automatic step(input bit wr, input logic [DW-1:0] d, input bit rdy, input bit fl);
    bit exp_vld;
    int sz;
    @(posedge CLK);
    #1;
    CONTROL_WR    = wr;
    CONTROL_DATA  = d;
    VEC_CMD_READY = rdy;
    FLUSH         = fl;
    #1;
    sz      = exp_q.size();
    exp_vld = (sz != 0);
`ifdef SIMD_CMDQ_BYPASS_EN
    if (wr && !fl && sz == 0) exp_vld = 1'b1;
`endif
    chk("cmd_count", 64'(CMD_COUNT), 64'(sz));
    chk("overflow",  64'(OVERFLOW), 64'(ovf_m));
    chk("core_busy", 64'(CORE_BUSY), 64'(sz == DEPTH));
    chk("vec_valid", 64'(VEC_CMD_VALID), 64'(exp_vld));
    chk("simd_idle", 64'(SIMD_IDLE), 64'(sz == 0 && !VEC_BUSY));
    if (fl) begin
      exp_q.delete();
    end else if (wr) begin
      if (sz < DEPTH || (rdy && exp_vld)) exp_q.push_back(d);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic fill8();
    for (int i = 1; i <= 8; i++) step(1'b1, 64'(i * 'h11), 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b1; CONTROL_WR = 1'b0; CONTROL_DATA = '0;
    FLUSH = 1'b0; VEC_CMD_READY = 1'b0; VEC_BUSY = 1'b0;
    ovf_m = 1'b0;

    // Reset state
    #2 RESET_N = 1'b0;
    #2;
    chk("rst_count", 64'(CMD_COUNT), 64'd0);
    chk("rst_valid", 64'(VEC_CMD_VALID), 64'd0);
    chk("rst_busy",  64'(CORE_BUSY), 64'd0);
    chk("rst_ovf",   64'(OVERFLOW), 64'd0);
    chk("rst_idle",  64'(SIMD_IDLE), 64'd1);
    VEC_BUSY = 1'b1;
    #1 chk("rst_idle_vbusy", 64'(SIMD_IDLE), 64'd0);
    VEC_BUSY = 1'b0;
    @(posedge CLK); #1 RESET_N = 1'b1;

    // Full queue, simultaneous push+pop: no overflow, count stays 8
    fill8();
    step(1'b1, 64'hAA, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    drain(9);

    // Fill, dropped 9th push, then in-order drain
    fill8();
    step(1'b1, 64'h99, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    drain(9);

    // Pointer wrap with READY toggling; VEC_BUSY raised part-way
    for (int i = 0; i < 20; i++) begin
      VEC_BUSY = (i >= 10 && i < 14);
      step(1'b1, 64'h100 + 64'(i), bit'(i % 2), 1'b0);
    end
    VEC_BUSY = 1'b0;
    drain(10);

    // Flush with a concurrent push and ready consumer
    step(1'b1, 64'h31, 1'b0, 1'b0);
    step(1'b1, 64'h32, 1'b0, 1'b0);
    step(1'b1, 64'h33, 1'b0, 1'b0);
    step(1'b1, 64'h55, 1'b1, 1'b1);
    drain(3);

    // Push-to-valid latency on an empty queue with a ready consumer
    step(1'b1, 64'h42, 1'b1, 1'b0);
    drain(2);

    // Reset in the middle of operation loses queued commands and OVERFLOW
    step(1'b1, 64'h61, 1'b0, 1'b0);
    step(1'b1, 64'h62, 1'b0, 1'b0);
    @(posedge CLK); #1 CONTROL_WR = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    exp_q.delete();
    ovf_m = 1'b0;
    chk("midrst_count", 64'(CMD_COUNT), 64'd0);
    chk("midrst_valid", 64'(VEC_CMD_VALID), 64'd0);
    chk("midrst_ovf",   64'(OVERFLOW), 64'd0);
    @(posedge CLK); #1 RESET_N = 1'b1;
    step(1'b1, 64'h77, 1'b0, 1'b0);
    drain(3);

    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL leftover: got %0d undelivered commands, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
